bus_arbiter_8: RTL and testbench
================================

BUS_ARBITER_8 -- requirements
Module: bus_arbiter_8

Interface
REQ-001 The block SHALL have one parameter: MAX_HOLD, 16, maximum grant tenure in cycles while others wait (range 2..255; used only with BUS_ARBITER_TIMEOUT_EN).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port req, input, 8, per-requester bus request; bit i belongs to requester i.
REQ-005 The block SHALL have port data_in, input, 128, requester data; lane i is bits [16*i+15:16*i].
REQ-006 The block SHALL have port gnt, output, 8, registered one-hot grant; all zero when no owner.
REQ-007 The block SHALL have port sel, output, 3, registered index of the current owner; this is the 8-to-1 mux select.
REQ-008 The block SHALL have port busy, output, 1, registered; 1 iff gnt is nonzero.
REQ-009 The block SHALL have port bus_data, output, 16, equal to data_in lane sel when busy=1 and 16'h0000 otherwise (combinational from registered sel/busy).

Function
REQ-010 The block SHALL implement two states, IDLE (no owner) and OWN (one owner), plus a 3-bit round-robin pointer last holding the most recently granted index.
REQ-011 In IDLE, when req is nonzero at a rising edge, the block SHALL enter OWN; gnt, sel and busy SHALL update at that same edge (1-cycle latency from req sample to grant).
REQ-012 The winner SHALL be the first set bit of req searching last+1, last+2, ... modulo 8 (wrap 7->0); last SHALL be loaded with the winner at grant.
REQ-013 In OWN, the owner SHALL keep the grant while req[sel]=1, irrespective of other requests, subject to REQ-016.
REQ-014 In OWN, when req[sel]=0 at an edge and another req bit is set, the block SHALL grant the next winner at that edge, with no idle cycle and no cycle with two grant bits set.
REQ-015 In OWN, when req[sel]=0 and req is all zero at an edge, the block SHALL return to IDLE with gnt=0, busy=0, and sel holding its last value.
REQ-016 A requester that drops and re-raises req while not owner SHALL wait its round-robin turn; an owner dropping req loses the grant even if it re-raises req in the next cycle.
REQ-017 gnt SHALL never have more than one bit set, and gnt[i]=1 only when busy=1 and sel=i.

Reset
REQ-018 On rst=1, regardless of clock, state SHALL be IDLE, gnt=8'h00, sel=3'd0, busy=0, last=3'd7 (requester 0 highest priority after reset), hold counter=0.
REQ-019 Reset asserted during OWN SHALL drop the grant immediately, and the first arbitration after release SHALL use last=7.

Configuration
REQ-020 With macro BUS_ARBITER_TIMEOUT_EN defined, an 8-bit hold counter SHALL clear at each grant and increment each OWN cycle; when it reaches MAX_HOLD-1 and any req other than the owner is set, the next edge SHALL grant the round-robin winner excluding the current owner.
REQ-021 With BUS_ARBITER_TIMEOUT_EN defined and no other request pending, the counter SHALL saturate at MAX_HOLD-1 and the owner SHALL keep the grant.
REQ-022 Without BUS_ARBITER_TIMEOUT_EN, no counter SHALL exist and an owner SHALL hold the grant indefinitely while its req is 1.

Verification
REQ-023 Release reset, req=8'h81 -> one edge later gnt=8'h01, sel=0; drop req[0] -> next edge gnt=8'h80, sel=7.
REQ-024 req=8'hFF with each owner dropping req for one cycle after 1 cycle of grant -> sel sequence 0,1,2,...,7,0 with busy continuously 1.
REQ-025 Lane i data=16'h1000+i, owner 5 -> bus_data=16'h1005; all req dropped -> busy=0, bus_data=16'h0000 on the next edge.
REQ-026 BUS_ARBITER_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 held -> gnt alternates 8'h01 and 8'h02 every 4 cycles; req=8'h01 alone -> gnt=8'h01 held for 20+ cycles.
REQ-027 rst pulsed mid-cycle while gnt=8'h08 -> gnt=0, busy=0 before the next edge; after release with req=8'h88 -> gnt=8'h08 (search starts at 0).
REQ-028 Every scenario SHALL check on every cycle that gnt is one-hot or zero and consistent with sel/busy.

Source files
------------

// File: rtl/bus_arbiter_8.sv
// 8-requester round-robin bus arbiter with registered one-hot grant and 16-bit data mux.
// Optional grant-tenure limit is compiled in with BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   req,
  input  logic [127:0] data_in,
  output logic [7:0]   gnt,
  output logic [2:0]   sel,
  output logic         busy,
  output logic [15:0]  bus_data
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_arbiter_8: MAX_HOLD out of range 2..255");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_gnt, w_gnt_nxt;
  logic [2:0] r_sel, w_sel_nxt;
  logic [2:0] r_last, w_last_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_grant;
  logic [3:0] w_pick;

  // Returns {found, index} of the first set mask bit searching last+1 .. last+8 (mod 8).
  function automatic logic [3:0] rr_pick(input logic [7:0] mask, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!res[3] && mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] r_hold, w_hold_nxt;
  logic       w_timeout;
  assign w_timeout = (r_hold == HOLD_LAST) && ((req & ~r_gnt) != 8'h00);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_busy_nxt  = r_busy;
    w_last_nxt  = r_last;
    w_grant     = 1'b0;
    // Masking the owner's bit lets a timeout skip it; otherwise its req is already 0.
    w_pick      = rr_pick(req & ~r_gnt, r_last);
    case (r_state)
      IDLE: if (|req) w_grant = 1'b1;
      OWN: begin
        if (!req[r_sel]) begin
          if (|req) begin
            w_grant = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = 8'h00;
            w_busy_nxt  = 1'b0;
          end
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (w_timeout) begin
          w_grant = 1'b1;
        end
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_grant) begin
      w_state_nxt = OWN;
      w_gnt_nxt   = 8'b1 << w_pick[2:0];
      w_sel_nxt   = w_pick[2:0];
      w_busy_nxt  = 1'b1;
      w_last_nxt  = w_pick[2:0];
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  always_comb begin
    w_hold_nxt = r_hold;
    if (w_grant)
      w_hold_nxt = 8'h00;
    else if (w_state_nxt == OWN && r_state == OWN && r_hold != HOLD_LAST)
      w_hold_nxt = r_hold + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hold <= 8'h00;
    else     r_hold <= w_hold_nxt;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= 8'h00;
      r_sel   <= 3'd0;
      r_busy  <= 1'b0;
      r_last  <= 3'd7;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= w_busy_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign sel      = r_sel;
  assign busy     = r_busy;
  assign bus_data = r_busy ? data_in[{r_sel, 4'b0000} +: 16] : 16'h0000;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed self-checking bench for bus_arbiter_8; timeout scenarios run when BUS_ARBITER_TIMEOUT_EN is defined.
module tb_bus_arbiter_8;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   req = 8'h00;
  logic [127:0] data_in;
  logic [7:0]   gnt;
  logic [2:0]   sel;
  logic         busy;
  logic [15:0]  bus_data;

  int n_cmp = 0;
  int n_err = 0;

  bus_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .gnt(gnt), .sel(sel), .busy(busy), .bus_data(bus_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: gnt is zero or one-hot and agrees with busy/sel.
  always @(negedge clk) begin
    logic [7:0] exp_g;
    exp_g = busy ? (8'b1 << sel) : 8'h00;
    chk("gnt_consistent", {24'h0, gnt}, {24'h0, exp_g});
    chk("gnt_onehot0", {31'h0, $onehot0(gnt)}, 32'h1);
  end

  initial begin
    for (int i = 0; i < 8; i++) data_in[16*i +: 16] = 16'h1000 + 16'(i);

    #2;
    chk("rst_gnt", {24'h0, gnt}, 32'h00);
    chk("rst_sel", {29'h0, sel}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_bus_data", {16'h0, bus_data}, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    req = 8'h81;
    tick();
    chk("first_gnt", {24'h0, gnt}, 32'h01);
    chk("first_sel", {29'h0, sel}, 32'h0);
    chk("first_data", {16'h0, bus_data}, 32'h1000);
    req = 8'h80;
    tick();
    chk("handover_gnt", {24'h0, gnt}, 32'h80);
    chk("handover_sel", {29'h0, sel}, 32'h7);
    chk("handover_data", {16'h0, bus_data}, 32'h1007);
    req = 8'h00;
    tick();
    chk("idle_gnt", {24'h0, gnt}, 32'h00);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_sel_held", {29'h0, sel}, 32'h7);
    chk("idle_data", {16'h0, bus_data}, 32'h0);

    // Full rotation: each owner drops for one cycle after one cycle of tenure.
    req = 8'hFF;
    tick();
    chk("rot_sel_0", {29'h0, sel}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      req = 8'hFF & ~(8'b1 << ((k - 1) % 8));
      tick();
      chk($sformatf("rot_sel_%0d", k), {29'h0, sel}, 32'(k % 8));
      chk($sformatf("rot_busy_%0d", k), {31'h0, busy}, 32'h1);
    end

    req = 8'h20;
    tick();
    chk("own5_gnt", {24'h0, gnt}, 32'h20);
    chk("own5_data", {16'h0, bus_data}, 32'h1005);
    req = 8'h00;
    tick();
    chk("drop_busy", {31'h0, busy}, 32'h0);
    chk("drop_data", {16'h0, bus_data}, 32'h0);
    chk("drop_sel", {29'h0, sel}, 32'h5);

    // Two contenders held: search from last=5 picks 0 first.
    req = 8'h03;
    for (int t = 1; t <= 16; t++) begin
      tick();
`ifdef BUS_ARBITER_TIMEOUT_EN
      chk($sformatf("tmo_alt_%0d", t), {24'h0, gnt}, ((((t - 1) / 4) % 2) == 0) ? 32'h01 : 32'h02);
`else
      chk($sformatf("hold_%0d", t), {24'h0, gnt}, 32'h01);
`endif
    end
    req = 8'h01;
    for (int t = 1; t <= 22; t++) begin
      tick();
      chk($sformatf("solo_hold_%0d", t), {24'h0, gnt}, 32'h01);
    end

    // Owner drops for one cycle and re-raises: it has lost the grant.
    req = 8'h02;
    tick();
    chk("drop_to_1", {24'h0, gnt}, 32'h02);
    req = 8'h03;
    tick();
    chk("reraise_waits", {24'h0, gnt}, 32'h02);

    req = 8'h08;
    tick();
    chk("own3_gnt", {24'h0, gnt}, 32'h08);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_gnt", {24'h0, gnt}, 32'h00);
    chk("async_rst_busy", {31'h0, busy}, 32'h0);
    chk("async_rst_sel", {29'h0, sel}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h88;
    tick();
    chk("post_rst_gnt", {24'h0, gnt}, 32'h08);
    chk("post_rst_sel", {29'h0, sel}, 32'h3);

    req = 8'h00;
    tick();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
